// File: rtl/axi_rd_arbiter_if.sv
// Bundle of the CPU SRAM-like read ports, the AXI AR/R channels and the status lines
// that the read arbiter sits between.
interface axi_rd_arbiter_if;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;

    logic        data_req;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    logic        wr_busy;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic        rd_err;

    // Arbiter side: drives AR and the requester responses.
    modport master (
        input  inst_req, inst_size, inst_addr,
        output inst_addr_ok, inst_rdata, inst_data_ok,
        input  data_req, data_size, data_addr,
        output data_addr_ok, data_rdata, data_data_ok,
        input  wr_busy,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready, rd_err
    );

    // Environment side: CPU requesters plus the AXI slave.
    modport slave (
        output inst_req, inst_size, inst_addr,
        input  inst_addr_ok, inst_rdata, inst_data_ok,
        output data_req, data_size, data_addr,
        input  data_addr_ok, data_rdata, data_data_ok,
        output wr_busy,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready, rd_err
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Arbitrates CPU instruction/data reads onto one AXI read channel: data priority with an
// instruction starvation guard, per-ID outstanding tracking and R-beat routing by rid.
module axi_rd_arbiter #(
    parameter int         MAX_OUT    = 2,
    parameter logic [3:0] INST_ID    = 4'd0,
    parameter logic [3:0] DATA_ID    = 4'd1,
    parameter int         STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset,
    axi_rd_arbiter_if.master  bus
);
    localparam logic [2:0] MAX_C = 3'(MAX_OUT);
    localparam logic [7:0] LIM_C = 8'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, AR_DATA, AR_INST} state_t;

    state_t      state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  arid_q, arid_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [7:0]  starve_q, starve_d;
    logic        rd_err_q, rd_err_d;
    logic        rready_q;

    logic        ar_hs, beat;
    logic        data_go, inst_go, inst_pri;
    logic        in_idle, grant_data, grant_inst;
    logic [2:0]  icnt, dcnt;
    logic [1:0][2:0] cnt;
    logic [1:0]  rid_hit, zero_hit;
    logic        rid_unknown;

    assign ar_hs = (state_q != IDLE) & bus.arready;
    assign beat  = bus.rvalid & rready_q & ~reset;

    assign icnt = cnt[0];
    assign dcnt = cnt[1];

    // Grant is combinational in IDLE so addr_ok answers in the request cycle.
    assign data_go    = bus.data_req & ~bus.wr_busy & (dcnt < MAX_C);
    assign inst_go    = bus.inst_req & (icnt < MAX_C);
    assign inst_pri   = inst_go & (starve_q == LIM_C);
    assign in_idle    = (state_q == IDLE) & ~reset;
    assign grant_data = in_idle & data_go & ~inst_pri;
    assign grant_inst = in_idle & inst_go & (inst_pri | ~data_go);

    // Index 0 tracks the instruction ID, index 1 the data ID.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        localparam logic [3:0] ID = (gi == 0) ? INST_ID : DATA_ID;
        logic [2:0] cnt_q, cnt_d;
        logic       ar_inc, r_dec;

        assign ar_inc       = ar_hs & (arid_q == ID);
        assign rid_hit[gi]  = beat & (bus.rid == ID);
        assign zero_hit[gi] = rid_hit[gi] & (cnt_q == 3'd0);
        // A last beat against an empty counter is an error, never an underflow.
        assign r_dec        = rid_hit[gi] & bus.rlast & (cnt_q != 3'd0);
        assign cnt[gi]      = cnt_q;

        always_comb begin
            cnt_d = cnt_q;
            case ({ar_inc, r_dec})
                2'b10:   cnt_d = cnt_q + 3'd1;
                2'b01:   cnt_d = cnt_q - 3'd1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) cnt_q <= 3'd0;
            else       cnt_q <= cnt_d;
        end
    end

    assign rid_unknown = beat & (bus.rid != INST_ID) & (bus.rid != DATA_ID);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            araddr_q <= 32'd0;
            arid_q   <= 4'd0;
            arsize_q <= 3'd0;
            starve_q <= 8'd0;
            rd_err_q <= 1'b0;
            rready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            arid_q   <= arid_d;
            arsize_q <= arsize_d;
            starve_q <= starve_d;
            rd_err_q <= rd_err_d;
            rready_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arid_d   = arid_q;
        arsize_d = arsize_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d  = AR_DATA;
                    araddr_d = bus.data_addr;
                    arsize_d = {1'b0, bus.data_size};
                    arid_d   = DATA_ID;
                end else if (grant_inst) begin
                    state_d  = AR_INST;
                    araddr_d = bus.inst_addr;
                    arsize_d = {1'b0, bus.inst_size};
                    arid_d   = INST_ID;
                end
                // Only consecutive data wins against a waiting fetch count toward starvation.
                if (grant_inst || !bus.inst_req)
                    starve_d = 8'd0;
                else if (grant_data && starve_q != LIM_C)
                    starve_d = starve_q + 8'd1;
            end
            AR_DATA, AR_INST: begin
                if (bus.arready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rd_err_d = rd_err_q
                 | (beat & (bus.rresp != 2'b00))
                 | rid_unknown
                 | (|zero_hit);
    end

    always_comb begin
        bus.arvalid      = (state_q != IDLE);
        bus.araddr       = araddr_q;
        bus.arid         = arid_q;
        bus.arsize       = arsize_q;
        bus.arlen        = 8'd0;
        bus.arburst      = 2'b01;
        bus.arlock       = 2'b00;
        bus.arcache      = 4'd0;
        bus.arprot       = 3'd0;
        bus.inst_addr_ok = grant_inst;
        bus.data_addr_ok = grant_data;
        bus.inst_data_ok = rid_hit[0];
        bus.data_data_ok = rid_hit[1];
        bus.inst_rdata   = bus.rdata;
        bus.data_rdata   = bus.rdata;
        bus.rready       = rready_q;
        bus.rd_err       = rd_err_q;
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: single read, starvation order, outstanding limit,
// write blocking, AR stall, error flag and mid-operation reset.
module tb_axi_rd_arbiter;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    axi_rd_arbiter_if bus();

    axi_rd_arbiter #(
        .MAX_OUT    (2),
        .INST_ID    (4'd0),
        .DATA_ID    (4'd1),
        .STARVE_LIM (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp);
        bus.rvalid = 1'b1;
        bus.rid    = id;
        bus.rdata  = d;
        bus.rresp  = resp;
        bus.rlast  = 1'b1;
    endtask

    logic        exp_d [6];
    logic [31:0] exp_addr;
    logic [3:0]  prev_id;

    initial begin
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        reset         = 1'b1;
        bus.inst_req  = 1'b1;
        bus.inst_size = 2'd2;
        bus.inst_addr = 32'h0;
        bus.data_req  = 1'b0;
        bus.data_size = 2'd2;
        bus.data_addr = 32'h0;
        bus.wr_busy   = 1'b0;
        bus.arready   = 1'b0;
        bus.rid       = 4'd0;
        bus.rdata     = 32'h0;
        bus.rresp     = 2'b00;
        bus.rlast     = 1'b1;
        bus.rvalid    = 1'b1;

        // Reset state, with a request and an R beat present to prove gating.
        tick();
        mid();
        check_eq("rst_arvalid", bus.arvalid, 0);
        check_eq("rst_araddr", bus.araddr, 0);
        check_eq("rst_arid", bus.arid, 0);
        check_eq("rst_arsize", bus.arsize, 0);
        check_eq("rst_rready", bus.rready, 0);
        check_eq("rst_rd_err", bus.rd_err, 0);
        check_eq("rst_inst_addr_ok", bus.inst_addr_ok, 0);
        check_eq("rst_inst_data_ok", bus.inst_data_ok, 0);
        check_eq("rst_icnt", dut.icnt, 0);
        tick();
        reset = 1'b0; bus.inst_req = 1'b0; bus.rvalid = 1'b0;
        tick();

        // Single instruction read.
        bus.arready = 1'b1;
        bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0000; bus.inst_size = 2'd2;
        mid();
        check_eq("rready_after_rst", bus.rready, 1);
        check_eq("t1_inst_addr_ok", bus.inst_addr_ok, 1);
        check_eq("t1_data_addr_ok", bus.data_addr_ok, 0);
        tick();
        bus.inst_req = 1'b0;
        mid();
        check_eq("t1_arvalid", bus.arvalid, 1);
        check_eq("t1_araddr", bus.araddr, 32'hBFC0_0000);
        check_eq("t1_arid", bus.arid, 0);
        check_eq("t1_arsize", bus.arsize, 2);
        check_eq("t1_arlen", bus.arlen, 0);
        check_eq("t1_arburst", bus.arburst, 1);
        check_eq("t1_addr_ok_busy", bus.inst_addr_ok, 0);
        $display("AR inst addr=%08h id=%0d", bus.araddr, bus.arid);
        tick();
        mid();
        check_eq("t1_arvalid_drop", bus.arvalid, 0);
        check_eq("t1_icnt_1", dut.icnt, 1);
        tick();
        r_beat(4'd0, 32'h3C1D_0000, 2'b00);
        mid();
        check_eq("t1_inst_data_ok", bus.inst_data_ok, 1);
        check_eq("t1_inst_rdata", bus.inst_rdata, 32'h3C1D_0000);
        check_eq("t1_data_data_ok", bus.data_data_ok, 0);
        $display("R  inst data=%08h", bus.inst_rdata);
        tick();
        bus.rvalid = 1'b0;
        mid();
        check_eq("t1_icnt_0", dut.icnt, 0);
        check_eq("t1_rd_err", bus.rd_err, 0);
        tick();

        // Starvation guard: both requesting, order D D D D I D; each read retired next grant.
        prev_id = 4'd0;
        for (int k = 0; k < 6; k++) begin
            bus.inst_req  = 1'b1; bus.inst_addr = 32'hBFC0_0100;
            bus.data_req  = 1'b1; bus.data_addr = 32'h8000_0000 + 32'(k * 16);
            if (k > 0) r_beat(prev_id, 32'h0, 2'b00);
            exp_addr = exp_d[k] ? (32'h8000_0000 + 32'(k * 16)) : 32'hBFC0_0100;
            mid();
            check_eq($sformatf("t2_data_ok_%0d", k), bus.data_addr_ok, 32'(exp_d[k]));
            check_eq($sformatf("t2_inst_ok_%0d", k), bus.inst_addr_ok, 32'(!exp_d[k]));
            tick();
            bus.rvalid = 1'b0;
            mid();
            check_eq($sformatf("t2_araddr_%0d", k), bus.araddr, exp_addr);
            check_eq($sformatf("t2_arid_%0d", k), bus.arid, exp_d[k] ? 32'd1 : 32'd0);
            $display("AR grant %0d port=%s addr=%08h", k, exp_d[k] ? "data" : "inst", bus.araddr);
            prev_id = exp_d[k] ? 4'd1 : 4'd0;
            tick();
        end
        bus.inst_req = 1'b0; bus.data_req = 1'b0;
        r_beat(4'd1, 32'h0, 2'b00);
        mid();
        check_eq("t2_last_retire", bus.data_data_ok, 1);
        tick();
        bus.rvalid = 1'b0;
        mid();
        check_eq("t2_dcnt", dut.dcnt, 0);
        check_eq("t2_icnt", dut.icnt, 0);
        tick();

        // Outstanding limit: two data reads fill dcnt, third blocked, inst still granted.
        for (int j = 0; j < 2; j++) begin
            bus.data_req = 1'b1; bus.data_addr = 32'h9000_0000 + 32'(j * 4);
            mid();
            check_eq($sformatf("t3_data_ok_%0d", j), bus.data_addr_ok, 1);
            tick();
            mid();
            $display("AR data addr=%08h", bus.araddr);
            tick();
        end
        bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0200;
        mid();
        check_eq("t3_dcnt_full", dut.dcnt, 2);
        check_eq("t3_third_blocked", bus.data_addr_ok, 0);
        check_eq("t3_inst_granted", bus.inst_addr_ok, 1);
        tick();
        bus.inst_req = 1'b0; bus.data_req = 1'b0;
        mid();
        check_eq("t3_arid_inst", bus.arid, 0);
        check_eq("t3_araddr_inst", bus.araddr, 32'hBFC0_0200);
        tick();
        r_beat(4'd1, 32'h0, 2'b00); tick();
        r_beat(4'd1, 32'h0, 2'b00); tick();
        r_beat(4'd0, 32'h0, 2'b00); tick();
        bus.rvalid = 1'b0;
        mid();
        check_eq("t3_dcnt_0", dut.dcnt, 0);
        check_eq("t3_icnt_0", dut.icnt, 0);
        check_eq("t3_rd_err", bus.rd_err, 0);
        tick();

        // Write busy blocks data grants; release grants in the same cycle.
        bus.data_req = 1'b1; bus.data_addr = 32'hA000_0000; bus.wr_busy = 1'b1;
        mid();
        check_eq("t4_blocked_0", bus.data_addr_ok, 0);
        tick();
        mid();
        check_eq("t4_blocked_1", bus.data_addr_ok, 0);
        tick();
        bus.wr_busy = 1'b0;
        mid();
        check_eq("t4_release", bus.data_addr_ok, 1);
        bus.arready = 1'b0;
        tick();
        bus.data_req = 1'b0; bus.wr_busy = 1'b1;
        mid();
        check_eq("t4_not_withdrawn", bus.arvalid, 1);
        check_eq("t4_arid", bus.arid, 1);
        bus.arready = 1'b1;
        tick();
        bus.wr_busy = 1'b0;
        r_beat(4'd1, 32'h0, 2'b00);
        tick();
        bus.rvalid = 1'b0;
        tick();

        // AR stall: payload stable, no addr_ok to either port while arvalid waits.
        bus.arready = 1'b0;
        bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0300;
        mid();
        check_eq("t5_grant", bus.inst_addr_ok, 1);
        tick();
        bus.inst_addr = 32'h1234_5678; bus.data_req = 1'b1; bus.data_addr = 32'h5555_0000;
        for (int s = 0; s < 5; s++) begin
            mid();
            check_eq($sformatf("t5_arvalid_%0d", s), bus.arvalid, 1);
            check_eq($sformatf("t5_araddr_%0d", s), bus.araddr, 32'hBFC0_0300);
            check_eq($sformatf("t5_arid_%0d", s), bus.arid, 0);
            check_eq($sformatf("t5_iok_%0d", s), bus.inst_addr_ok, 0);
            check_eq($sformatf("t5_dok_%0d", s), bus.data_addr_ok, 0);
            tick();
        end
        bus.arready = 1'b1; bus.inst_req = 1'b0; bus.data_req = 1'b0;
        tick();
        mid();
        check_eq("t5_released", bus.arvalid, 0);
        check_eq("t5_icnt", dut.icnt, 1);
        tick();
        r_beat(4'd0, 32'h0, 2'b00);
        tick();
        bus.rvalid = 1'b0;

        // Unknown rid: flagged, not forwarded, counters untouched, sticky until reset.
        r_beat(4'd7, 32'h0, 2'b00);
        mid();
        check_eq("t6_unk_inst_ok", bus.inst_data_ok, 0);
        check_eq("t6_unk_data_ok", bus.data_data_ok, 0);
        check_eq("t6_err_pre", bus.rd_err, 0);
        tick();
        bus.rvalid = 1'b0;
        mid();
        check_eq("t6_err_set", bus.rd_err, 1);
        check_eq("t6_icnt", dut.icnt, 0);
        check_eq("t6_dcnt", dut.dcnt, 0);
        tick(); tick();
        mid();
        check_eq("t6_err_sticky", bus.rd_err, 1);
        tick();
        reset = 1'b1;
        tick();
        mid();
        check_eq("t6_err_cleared", bus.rd_err, 0);
        tick();
        reset = 1'b0;
        tick();

        // Error response on an idle ID: flagged, forwarded, no underflow.
        r_beat(4'd0, 32'h1111_2222, 2'b10);
        mid();
        check_eq("t6_slverr_fwd", bus.inst_data_ok, 1);
        tick();
        bus.rvalid = 1'b0; bus.rresp = 2'b00;
        mid();
        check_eq("t6_slverr_err", bus.rd_err, 1);
        check_eq("t6_no_underflow", dut.icnt, 0);
        tick();

        // Reset during AR_DATA drops arvalid; a late beat afterwards is forwarded and flagged.
        bus.arready = 1'b0;
        bus.data_req = 1'b1; bus.data_addr = 32'hB000_0000;
        mid();
        check_eq("t7_grant", bus.data_addr_ok, 1);
        tick();
        bus.data_req = 1'b0;
        mid();
        check_eq("t7_arvalid", bus.arvalid, 1);
        tick();
        reset = 1'b1;
        tick();
        mid();
        check_eq("t7_arvalid_drop", bus.arvalid, 0);
        check_eq("t7_dcnt_lost", dut.dcnt, 0);
        tick();
        reset = 1'b0; bus.arready = 1'b1;
        tick();
        r_beat(4'd1, 32'hDEAD_BEEF, 2'b00);
        mid();
        check_eq("t7_late_fwd", bus.data_data_ok, 1);
        check_eq("t7_late_rdata", bus.data_rdata, 32'hDEAD_BEEF);
        check_eq("t7_err_pre", bus.rd_err, 0);
        tick();
        bus.rvalid = 1'b0;
        mid();
        check_eq("t7_late_err", bus.rd_err, 1);
        check_eq("t7_dcnt", dut.dcnt, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
